fm0_fifo_tx: RTL and testbench

- FIFO drain / tag backscatter transmitter. It is the read-side consumer of the byte FIFO.
- On start, it emits the Gen2 FM0 preamble, then pops bytes from the FIFO and FM0-encodes them MSB first.
- When the FIFO runs dry it appends the dummy-1 end bit.
- Sits between the FIFO output port and the modulator driver.

---
 rtl/fm0_pkg.sv | 8 +
 rtl/fm0_fifo_tx_if.sv | 9 +
 rtl/fm0_bit_timer.sv | 25 ++
 rtl/fm0_fifo_tx.sv | 114 +++++++++++
 tb/tb_fm0_fifo_tx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fm0_pkg.sv
// fm0_pkg: shared state type and frame constants for the FM0 FIFO transmitter
package fm0_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int PRE_LEN = 6;
  localparam logic [PRE_LEN-1:0] PREAMBLE_BITS = 6'b101001;
  localparam int VIOL_IDX = 4;
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DUMMY, DONE} state_t;
endpackage

// File: rtl/fm0_fifo_tx_if.sv
// fm0_fifo_tx_if: byte FIFO read port between the FIFO (slave) and the FM0 transmitter (master)
interface fm0_fifo_tx_if import fm0_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic empty;
  logic read;
  logic read_valid;
  logic [DATA_W-1:0] data_in;
  modport master (output read, input empty, read_valid, data_in);
  modport slave (input read, output empty, read_valid, data_in);
endinterface

// File: rtl/fm0_bit_timer.sv
// fm0_bit_timer: half-period counter producing mid-bit and bit-end strobes
module fm0_bit_timer import fm0_pkg::*; #(parameter int CNT_W = 9) (
  input logic clk,
  input logic reset_n,
  input logic en,
  input logic run,
  input logic [CNT_W-1:0] half_m1,
  output logic mid_tick,
  output logic bit_end
);
  logic [CNT_W-1:0] cnt;
  logic ph;
  logic wrap;
  assign wrap = run && cnt == half_m1;
  assign mid_tick = wrap && !ph;
  assign bit_end = wrap && ph;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      ph <= 1'b0;
    end else if (en) begin
      cnt <= (!run || wrap) ? '0 : cnt + 1'b1;
      ph <= run && (ph ^ wrap);
    end
endmodule

// File: rtl/fm0_fifo_tx.sv
// fm0_fifo_tx: drains the byte FIFO into a Gen2 FM0 frame (preamble, data MSB first, dummy-1)
module fm0_fifo_tx import fm0_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = 9
) (
  input logic clk,
  input logic reset_n,
  input logic en,
  input logic start,
  input logic [CNT_W-1:0] clock_divider,
  fm0_fifo_tx_if.master fifo,
  output logic tx_out,
  output logic busy,
  output logic done,
  output logic underrun,
  output logic [7:0] byte_count
);
  localparam int IDX_W = $clog2(DATA_W > PRE_LEN ? DATA_W : PRE_LEN);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_LEN - 1);
  localparam logic [IDX_W-1:0] PRE_REQ = IDX_W'(PRE_LEN - 2);
  localparam logic [IDX_W-1:0] PRE_VIOL = IDX_W'(VIOL_IDX - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] DATA_REQ = IDX_W'(DATA_W - 2);
  state_t state;
  logic [CNT_W-1:0] half_m1;
  logic [IDX_W-1:0] idx;
  logic [PRE_LEN-1:0] pre;
  logic [DATA_W-1:0] sh, nxt, got_data;
  logic have, pend, read_r;
  logic mid_tick, bit_end, cur_bit, last_bit, no_flip, req, got;
  fm0_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .run(busy),
    .half_m1(half_m1),
    .mid_tick(mid_tick),
    .bit_end(bit_end)
  );
  assign fifo.read = read_r && en;
  assign cur_bit = state == DATA ? sh[DATA_W-1] : pre[PRE_LEN-1];
  assign last_bit = state == PREAMBLE ? idx == PRE_LAST : idx == DATA_LAST;
  assign no_flip = state == PREAMBLE && idx == PRE_VIOL;
  assign req = bit_end && !fifo.empty && ((state == PREAMBLE && idx == PRE_REQ) || (state == DATA && idx == DATA_REQ));
  assign got = have || (pend && fifo.read_valid);
  assign got_data = have ? nxt : fifo.data_in;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      half_m1 <= '0;
      idx <= '0;
      pre <= '0;
      sh <= '0;
      nxt <= '0;
      have <= 1'b0;
      pend <= 1'b0;
      read_r <= 1'b0;
      tx_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
      byte_count <= '0;
    end else if (en) begin
      read_r <= req;
      done <= 1'b0;
      if (req) begin
        pend <= 1'b1;
        have <= 1'b0;
      end else if (pend && fifo.read_valid) begin
        nxt <= fifo.data_in;
        have <= 1'b1;
        pend <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state <= PREAMBLE;
          half_m1 <= clock_divider;
          pre <= PREAMBLE_BITS;
          idx <= '0;
          busy <= 1'b1;
          tx_out <= 1'b1;
          byte_count <= '0;
          underrun <= 1'b0;
          have <= 1'b0;
          pend <= 1'b0;
        end
        PREAMBLE, DATA: begin
          if (mid_tick && !cur_bit) tx_out <= !tx_out;
          if (bit_end) begin
            pre <= pre << 1;
            sh <= sh << 1;
            idx <= idx + 1'b1;
            tx_out <= no_flip ? tx_out : !tx_out;
            if (last_bit) begin
              if (state == DATA && byte_count != 8'hff) byte_count <= byte_count + 8'd1;
              if (pend && !fifo.read_valid) underrun <= 1'b1;
              state <= got ? DATA : DUMMY;
              sh <= got_data;
              idx <= '0;
              have <= 1'b0;
              pend <= 1'b0;
            end
          end
        end
        DUMMY: if (bit_end) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          tx_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fm0_fifo_tx.sv
// tb_fm0_fifo_tx: randomized frames checked cycle by cycle against an FM0 waveform model
module tb_fm0_fifo_tx;
  logic clk = 1'b0;
  logic reset_n, en, start;
  logic [8:0] clock_divider;
  logic tx_out, busy, done, underrun;
  logic [7:0] byte_count;
  int total = 0;
  int bad = 0;
  logic [7:0] bq[$];
  logic [7:0] fq[$];
  int lat = 0;
  int rv_cnt = -1;
  logic [7:0] rv_data = 8'h00;
  fm0_fifo_tx_if #(.DATA_W(8)) fif ();
  fm0_fifo_tx #(.DATA_W(8), .CNT_W(9)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .start(start),
    .clock_divider(clock_divider),
    .fifo(fif),
    .tx_out(tx_out),
    .busy(busy),
    .done(done),
    .underrun(underrun),
    .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [12:0] obs();
    return {tx_out, busy, fif.read, done, underrun, byte_count};
  endfunction
  function automatic logic [7:0] sat8(input int v);
    return v > 255 ? 8'hff : 8'(v);
  endfunction
  task automatic fifo_step();
    fif.read_valid = 1'b0;
    fif.data_in = 8'($urandom);
    if (fif.read) begin
      rv_data = 8'h00;
      if (fq.size() > 0) rv_data = fq.pop_front();
      rv_cnt = lat;
    end
    if (rv_cnt == 0) begin
      fif.read_valid = 1'b1;
      fif.data_in = rv_data;
    end
    if (rv_cnt >= 0) rv_cnt--;
    fif.empty = fq.size() == 0;
  endtask
  task automatic cyc();
    @(negedge clk);
    fifo_step();
  endtask
  task automatic frame(input int cd, input int lt, input int hold_at, input int sb_at, input int rst_at);
    int bits[$];
    int rd_at[$];
    logic [12:0] ew[$];
    int h, k, nb, lvl, p, guard, held, nbusy;
    logic ur, rd, aborted;
    logic [7:0] bc;
    h = cd + 1;
    bits = '{1, 0, 1, 0, 0, 1};
    k = 0;
    nb = 0;
    ur = 1'b0;
    while (k < bq.size()) begin
      rd_at.push_back((bits.size() - 1) * 2 * h);
      k++;
      if (lt > 2 * h - 1) begin
        ur = 1'b1;
        break;
      end
      for (int b = 7; b >= 0; b--) bits.push_back(int'(bq[k-1][b]));
      nb++;
    end
    bits.push_back(1);
    lvl = 0;
    foreach (bits[i]) begin
      if (i != 4) lvl ^= 1;
      for (int c = 0; c < 2 * h; c++) begin
        if (c == h && bits[i] == 0) lvl ^= 1;
        rd = 1'b0;
        foreach (rd_at[j]) if (rd_at[j] == ew.size()) rd = 1'b1;
        bc = sat8(i < 6 ? 0 : (i - 6) / 8);
        ew.push_back({lvl[0], 1'b1, rd, 1'b0, ur && i == bits.size() - 1, bc});
      end
    end
    ew.push_back({4'b0001, ur, sat8(nb)});
    ew.push_back({4'b0000, ur, sat8(nb)});
    fq = bq;
    lat = lt;
    rv_cnt = -1;
    fif.empty = fq.size() == 0;
    clock_divider = 9'(cd);
    start = 1'b1;
    p = 0;
    guard = 0;
    held = 0;
    nbusy = 0;
    aborted = 1'b0;
    while (p < ew.size() && guard < ew.size() + 40) begin
      cyc();
      start = 1'b0;
      guard++;
      nbusy += int'(busy);
      check("wave", obs(), ew[p]);
      if (p == rst_at) begin
        reset_n = 1'b0;
        #1 check("async_rst", obs(), 0);
        cyc();
        reset_n = 1'b1;
        fq.delete();
        rv_cnt = -1;
        repeat (3) begin
          cyc();
          check("post_rst", obs(), 0);
        end
        aborted = 1'b1;
        break;
      end
      if (p == sb_at) start = 1'b1;
      en = !(p == hold_at && held < 10);
      if (en) p++;
      else held++;
    end
    en = 1'b1;
    if (!aborted) begin
      check("frame_len", p, ew.size());
      check("busy_len", nbusy, bits.size() * 2 * h + (hold_at >= 0 ? 10 : 0));
      check("pops", bq.size() - fq.size(), k);
      repeat (2 * h + 4) cyc();
      check("ur_sticky", obs(), {4'b0000, ur, sat8(nb)});
    end
    fq.delete();
  endtask
  initial begin
    int cd, lt;
    reset_n = 1'b0;
    en = 1'b1;
    start = 1'b0;
    clock_divider = '0;
    fif.empty = 1'b1;
    fif.read_valid = 1'b0;
    fif.data_in = '0;
    repeat (3) cyc();
    check("reset", obs(), 0);
    reset_n = 1'b1;
    cyc();
    bq = '{8'hA5};
    frame(1, 1, -1, -1, -1);
    bq.delete();
    frame(1, 1, -1, -1, -1);
    bq = '{8'h00, 8'hFF, 8'h3C};
    frame(1, 2, -1, -1, -1);
    bq = '{8'h5A};
    frame(1, 5, -1, -1, -1);
    bq = '{8'hC3, 8'h81};
    frame(1, 1, 33, -1, -1);
    bq = '{8'h96, 8'h17};
    frame(2, 1, -1, -1, 56);
    bq = '{8'h42};
    frame(0, 0, -1, -1, -1);
    bq = '{8'h6E};
    frame(1, 1, -1, 10, -1);
    bq.delete();
    repeat (257) bq.push_back(8'($urandom));
    frame(0, 0, -1, -1, -1);
    repeat (25) begin
      cd = int'($urandom_range(0, 3));
      lt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2 * cd + 2, 2 * cd + 4)) : int'($urandom_range(0, 2 * cd + 1));
      bq.delete();
      repeat ($urandom_range(0, 4)) bq.push_back(8'($urandom));
      frame(cd, lt, -1, -1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
